// File: rtl/stress_trend_pkg.sv
// rtl/stress_trend_pkg.sv - shared constants and the calm-combine helper for stress_trend
package stress_trend_pkg;

  localparam logic MODE_ANY = 1'b0;
  localparam logic MODE_ALL = 1'b1;
  localparam int   CNT_W    = 4;

  // Inputs are zero-padded to 8 channels; padded lanes have en=0 so they never vote.
  function automatic logic combine_calm(input logic [7:0] calm, input logic [7:0] en,
                                        input logic mode);
    if (en == 8'd0) return 1'b0;
    if (mode == MODE_ALL) return &(calm | ~en);
    return |(calm & en);
  endfunction

endpackage

// File: rtl/stress_trend_chan.sv
// rtl/stress_trend_chan.sv - per-channel coarse-level trend tracker with saturating fall counter
module stress_trend_chan
  import stress_trend_pkg::*;
#(
  parameter int W     = 8,
  parameter int QBITS = 3,
  parameter int HOLD  = 2
) (
  input  logic         clk,
  input  logic         r,
  input  logic         valid,
  input  logic         en,
  input  logic [W-1:0] sample,
  output logic         calm
);

  logic [QBITS-1:0] q;
  logic [QBITS-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;

  assign q = sample[W-1 -: QBITS];

  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (valid && en) begin
      prev_d   = q;
      primed_d = 1'b1;
      // The first sample only establishes a reference level.
      if (!primed_q) begin
        cnt_d = cnt_q;
      end else if (q < prev_q) begin
        cnt_d = (cnt_q >= CNT_W'(HOLD)) ? CNT_W'(HOLD) : cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
    end
  end

  assign calm = (cnt_q == CNT_W'(HOLD)) && en;

endmodule

// File: rtl/stress_trend.sv
// rtl/stress_trend.sv - multi-channel stress-decreasing detector with ANY/ALL combine and rise pulse
module stress_trend
  import stress_trend_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int W     = 8,
  parameter int QBITS = 3,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             r,
  input  logic             smp_valid,
  input  logic [NCH*W-1:0] smp_data,
  input  logic [NCH-1:0]   ch_en,
  input  logic             mode_all,
  output logic             stress_low,
  output logic             stress_pulse,
  output logic [NCH-1:0]   ch_calm
);

  logic [NCH-1:0] calm_w;
  logic [NCH-1:0] ch_calm_q, ch_calm_d;
  logic           low_q, low_d;
  logic           pulse_q, pulse_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    stress_trend_chan #(
      .W    (W),
      .QBITS(QBITS),
      .HOLD (HOLD)
    ) u_chan (
      .clk   (clk),
      .r     (r),
      .valid (smp_valid),
      .en    (ch_en[i]),
      .sample(smp_data[i*W +: W]),
      .calm  (calm_w[i])
    );
  end

  // Combine is re-evaluated every cycle so mask/mode changes apply without a new sample.
  always_comb begin
    ch_calm_d = calm_w;
    low_d     = combine_calm(8'(calm_w), 8'(ch_en), mode_all);
    pulse_d   = low_d && !low_q;
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      ch_calm_q <= '0;
      low_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      ch_calm_q <= ch_calm_d;
      low_q     <= low_d;
      pulse_q   <= pulse_d;
    end
  end

  assign ch_calm      = ch_calm_q;
  assign stress_low   = low_q;
  assign stress_pulse = pulse_q;

endmodule

// File: tb/tb_stress_trend.sv
// tb/tb_stress_trend.sv - directed table-driven bench for stress_trend
module tb_stress_trend;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic [1:0]  ch_en = '0;
  logic        mode_all = 1'b0;
  logic        stress_low, stress_pulse;
  logic [1:0]  ch_calm;
  logic        h1_low, h1_pulse;
  logic [1:0]  h1_calm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stress_trend #(.NCH(2), .W(8), .QBITS(3), .HOLD(2)) dut (
    .clk(clk), .r(r), .smp_valid(smp_valid), .smp_data(smp_data), .ch_en(ch_en),
    .mode_all(mode_all), .stress_low(stress_low), .stress_pulse(stress_pulse), .ch_calm(ch_calm)
  );

  stress_trend #(.NCH(2), .W(8), .QBITS(3), .HOLD(1)) dut_h1 (
    .clk(clk), .r(r), .smp_valid(smp_valid), .smp_data(smp_data), .ch_en(ch_en),
    .mode_all(mode_all), .stress_low(h1_low), .stress_pulse(h1_pulse), .ch_calm(h1_calm)
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d1;
    logic [7:0] d0;
    logic [1:0] en;
    logic       mode;
    logic [1:0] calm;
    logic       low;
    logic       pulse;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rr, input logic v, input logic [7:0] d1, input logic [7:0] d0,
                      input logic [1:0] en, input logic mode);
    r = rr; smp_valid = v; smp_data = {d1, d0}; ch_en = en; mode_all = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [1:0] c, input logic l, input logic p);
    chk({tag, ".ch_calm"}, 32'(ch_calm), 32'(c));
    chk({tag, ".stress_low"}, 32'(stress_low), 32'(l));
    chk({tag, ".stress_pulse"}, 32'(stress_pulse), 32'(p));
  endtask

  initial begin
    //         r  v   d1     d0    en     mode  calm   low pulse
    vecs[0]  = '{0, 0, 8'h00, 8'h00, 2'b00, 0, 2'b00, 0, 0};
    vecs[1]  = '{1, 1, 8'h80, 8'hE0, 2'b11, 0, 2'b00, 0, 0};
    vecs[2]  = '{1, 1, 8'h80, 8'hC0, 2'b11, 0, 2'b00, 0, 0};
    vecs[3]  = '{1, 1, 8'h80, 8'hA0, 2'b11, 0, 2'b00, 0, 0};
    vecs[4]  = '{1, 0, 8'h80, 8'hA0, 2'b11, 0, 2'b01, 1, 1};
    vecs[5]  = '{1, 0, 8'h80, 8'hA0, 2'b11, 0, 2'b01, 1, 0};
    vecs[6]  = '{1, 1, 8'h80, 8'hA0, 2'b11, 0, 2'b01, 1, 0};
    vecs[7]  = '{1, 0, 8'h80, 8'hA0, 2'b11, 0, 2'b00, 0, 0};
    vecs[8]  = '{1, 1, 8'h80, 8'h80, 2'b11, 0, 2'b00, 0, 0};
    vecs[9]  = '{1, 1, 8'h80, 8'h60, 2'b11, 0, 2'b00, 0, 0};
    vecs[10] = '{1, 1, 8'h80, 8'h40, 2'b11, 0, 2'b01, 1, 1};
    vecs[11] = '{1, 1, 8'h80, 8'h20, 2'b11, 0, 2'b01, 1, 0};
    vecs[12] = '{1, 0, 8'h80, 8'h20, 2'b11, 1, 2'b01, 0, 0};
    vecs[13] = '{1, 0, 8'h80, 8'h20, 2'b01, 1, 2'b01, 1, 1};
    vecs[14] = '{1, 0, 8'h80, 8'h20, 2'b01, 1, 2'b01, 1, 0};
    vecs[15] = '{1, 0, 8'h80, 8'h20, 2'b00, 1, 2'b00, 0, 0};
    vecs[16] = '{1, 0, 8'h80, 8'h20, 2'b00, 0, 2'b00, 0, 0};
    vecs[17] = '{1, 1, 8'h80, 8'h00, 2'b10, 0, 2'b00, 0, 0};
    vecs[18] = '{1, 0, 8'h80, 8'h00, 2'b11, 0, 2'b01, 1, 1};
    vecs[19] = '{1, 1, 8'h60, 8'h00, 2'b11, 0, 2'b01, 1, 0};
    vecs[20] = '{1, 1, 8'h40, 8'h00, 2'b11, 0, 2'b01, 1, 0};
    vecs[21] = '{1, 0, 8'h40, 8'h00, 2'b11, 1, 2'b10, 0, 0};
    vecs[22] = '{1, 0, 8'h40, 8'h00, 2'b11, 0, 2'b10, 1, 1};

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].d1, vecs[i].d0, vecs[i].en, vecs[i].mode);
      chk_main($sformatf("vec%0d", i), vecs[i].calm, vecs[i].low, vecs[i].pulse);
    end

    // Invalid samples with churning data must not disturb any state.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'($urandom), 8'($urandom), 2'b11, 0);
      chk_main($sformatf("hold%0d", i), 2'b10, 1, 0);
    end

    // Reset wins over a valid sample; the next sample only primes.
    step(0, 1, 8'h00, 8'h00, 2'b11, 0);
    chk_main("rst_override", 2'b00, 0, 0);
    step(1, 1, 8'h80, 8'h80, 2'b11, 0);
    chk_main("rst_prime", 2'b00, 0, 0);
    step(1, 1, 8'h80, 8'h60, 2'b11, 0);
    chk_main("rst_dec1", 2'b00, 0, 0);
    step(1, 1, 8'h80, 8'h40, 2'b11, 0);
    chk_main("rst_dec2", 2'b00, 0, 0);
    step(1, 0, 8'h80, 8'h40, 2'b11, 0);
    chk_main("rst_calm", 2'b01, 1, 1);

    // HOLD=1 instance: a first sample of 0xFF never counts, the following 0x00 does.
    step(0, 0, 8'h00, 8'h00, 2'b01, 0);
    chk("h1_reset.calm", 32'(h1_calm), 32'h0);
    step(1, 1, 8'h00, 8'hFF, 2'b01, 0);
    chk("h1_first.calm", 32'(h1_calm), 32'h0);
    step(1, 1, 8'h00, 8'h00, 2'b01, 0);
    chk("h1_after_first.calm", 32'(h1_calm), 32'h0);
    chk("h1_after_first.low", 32'(h1_low), 32'h0);
    step(1, 0, 8'h00, 8'h00, 2'b01, 0);
    chk("h1_second.calm", 32'(h1_calm), 32'h1);
    chk("h1_second.low", 32'(h1_low), 32'h1);
    chk("h1_second.pulse", 32'(h1_pulse), 32'h1);
    step(1, 0, 8'h00, 8'h00, 2'b01, 0);
    chk("h1_hold.pulse", 32'(h1_pulse), 32'h0);
    chk("h1_hold.low", 32'(h1_low), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
